// File: rtl/field_halve_arb.sv
// Round-robin arbiter sharing one multi-cycle GF(p) halver (a/2 mod p) among
// n_req requesters; includes the halver so the block is self-contained.

module field_halve #(
    parameter int                 F_NBITS      = 61,
    parameter int                 F_ADD_CYCLES = 2,
    parameter logic [F_NBITS-1:0] F_PRIME      = {F_NBITS{1'b1}}
) (
    input  logic               clk,
    input  logic               rstb,
    input  logic               en,
    input  logic [F_NBITS-1:0] a,
    output logic               ready,
    output logic               ready_pulse,
    output logic [F_NBITS-1:0] c
);
    localparam int CW = (F_ADD_CYCLES < 2) ? 1 : $clog2(F_ADD_CYCLES + 1);

    logic [CW-1:0]  cnt;
    logic           init_q;
    logic [F_NBITS:0] sum;

    // Odd operands get p added first so the shift is an exact division by 2.
    always_comb sum = {1'b0, a} + (a[0] ? {1'b0, F_PRIME} : '0);

    // NOTE: sequential state is only ever written with non-blocking assignments.
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            cnt    <= '0;
            init_q <= 1'b0;
            c      <= '0;
        end else begin
            init_q <= 1'b1;
            if (en && ready) begin
                cnt <= CW'(F_ADD_CYCLES);
                c   <= sum[F_NBITS:1];
            end else if (cnt != '0) begin
                cnt <= cnt - CW'(1);
            end
        end
    end

    assign ready       = init_q && (cnt == '0);
    assign ready_pulse = (cnt == CW'(1));
endmodule

module field_halve_arb #(
    parameter int                 n_req        = 4,
    parameter int                 F_NBITS      = 61,
    parameter int                 F_ADD_CYCLES = 2,
    parameter logic [F_NBITS-1:0] F_PRIME      = {F_NBITS{1'b1}}
) (
    input  logic                       clk,
    input  logic                       rstb,
    input  logic [n_req-1:0]           req,
    input  logic [n_req*F_NBITS-1:0]   a_flat,
    output logic [n_req-1:0]           done,
    output logic [F_NBITS-1:0]         c,
    output logic                       gnt_vld,
    output logic [$clog2(n_req)-1:0]   gnt_idx,
    output logic                       busy
);
    localparam int IW = $clog2(n_req);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]         state;
    logic [IW-1:0]      ptr;
    logic [IW-1:0]      win;
    logic               found;
    logic [F_NBITS-1:0] a_q;
    logic [F_NBITS-1:0] ops [n_req];
    logic               halve_en;
    logic               halve_ready;
    logic               halve_ready_pulse;
    logic [F_NBITS-1:0] halve_c;

    for (genvar g = 0; g < n_req; g++) begin : g_ops
        assign ops[g] = a_flat[g*F_NBITS +: F_NBITS];
    end

    // Search starts just past the last grantee and wraps, so each requester
    // waits at most n_req-1 other grants.
    always_comb begin
        int idx;
        // NOTE: every combinational output gets a default first, so no latch is inferred.
        found = 1'b0;
        win   = '0;
        idx   = 0;
        for (int k = 1; k <= n_req; k++) begin
            idx = int'(ptr) + k;
            if (idx >= n_req) idx = idx - n_req;
            if (!found && req[idx]) begin
                found = 1'b1;
                win   = IW'(idx);
            end
        end
    end

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            state   <= S_IDLE;
            ptr     <= IW'(n_req - 1);
            gnt_idx <= '0;
            a_q     <= '0;
            c       <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (found && halve_ready) begin
                        a_q     <= ops[win];
                        gnt_idx <= win;
                        ptr     <= win;
                        state   <= S_ISSUE;
                    end
                end
                S_ISSUE: state <= S_WAIT;
                S_WAIT: begin
                    if (halve_ready_pulse) begin
                        c     <= halve_c;
                        state <= S_DONE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign halve_en = (state == S_ISSUE);
    assign gnt_vld  = (state != S_IDLE);
    assign busy     = (state != S_IDLE);
    assign done     = (state == S_DONE) ? ({{(n_req-1){1'b0}}, 1'b1} << gnt_idx) : '0;

    field_halve #(
        .F_NBITS      (F_NBITS),
        .F_ADD_CYCLES (F_ADD_CYCLES),
        .F_PRIME      (F_PRIME)
    ) u_halve (
        .clk         (clk),
        .rstb        (rstb),
        .en          (halve_en),
        .a           (a_q),
        .ready       (halve_ready),
        .ready_pulse (halve_ready_pulse),
        .c           (halve_c)
    );
endmodule

// File: tb/tb_field_halve_arb.sv
// Self-checking bench for field_halve_arb: directed scenarios plus randomized
// arbitration rounds checked against a round-robin / modular-halving model.

module tb_field_halve_arb;
    localparam int N  = 4;
    localparam int FB = 61;
    localparam int FA = 3;
    localparam logic [FB-1:0] P = 61'h1FFF_FFFF_FFFF_FFFF;
    localparam longint unsigned P_INT = 64'h1FFF_FFFF_FFFF_FFFF;

    logic              clk = 1'b0;
    logic              rstb;
    logic [N-1:0]      req;
    logic [N*FB-1:0]   a_flat;
    logic [N-1:0]      done;
    logic [FB-1:0]     c;
    logic              gnt_vld;
    logic [1:0]        gnt_idx;
    logic              busy;

    logic [FB-1:0] ops [N];
    int checks = 0;
    int errors = 0;
    int m_ptr  = N - 1;

    always #5 clk = ~clk;

    always_comb begin
        a_flat = '0;
        for (int i = 0; i < N; i++) a_flat[i*FB +: FB] = ops[i];
    end

    field_halve_arb #(
        .n_req(N), .F_NBITS(FB), .F_ADD_CYCLES(FA), .F_PRIME(P)
    ) dut (
        .clk(clk), .rstb(rstb), .req(req), .a_flat(a_flat), .done(done),
        .c(c), .gnt_vld(gnt_vld), .gnt_idx(gnt_idx), .busy(busy)
    );

    function automatic logic [FB-1:0] halve_ref(input logic [FB-1:0] a);
        longint unsigned v;
        v = 64'(a);
        if (v % 2 == 1) v = v + P_INT;
        return FB'(v / 2);
    endfunction

    function automatic int rr_model(input logic [N-1:0] mask);
        for (int k = 1; k <= N; k++) begin
            if (mask[(m_ptr + k) % N]) return (m_ptr + k) % N;
        end
        return -1;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs(input string name);
        checks++;
        if (done !== '0 || c !== '0 || gnt_vld !== 1'b0 || gnt_idx !== '0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL %s: done=%b c=%h gnt_vld=%b gnt_idx=%0d busy=%b, expected all zero",
                     name, done, c, gnt_vld, gnt_idx, busy);
        end
    endtask

    // Hold a request mask until a done strobe, check winner and result against the model.
    task automatic do_arb(input logic [N-1:0] mask, input string name, output int won);
        int  exp;
        bit  seen;
        exp  = rr_model(mask);
        req  = mask;
        seen = 0;
        won  = -1;
        for (int k = 0; k < 60 && !seen; k++) begin
            tick();
            if (done !== '0) seen = 1;
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL %s: no done within 60 cycles, req=%b", name, mask);
            req = '0;
            return;
        end
        for (int i = 0; i < N; i++) if (done[i]) won = i;
        checks++;
        if (done !== (4'b0001 << exp)) begin
            errors++;
            $display("FAIL %s: done=%b expected %b", name, done, 4'b0001 << exp);
        end
        checks++;
        if (c !== halve_ref(ops[exp])) begin
            errors++;
            $display("FAIL %s: c=%h expected %h", name, c, halve_ref(ops[exp]));
        end
        checks++;
        if (gnt_idx !== 2'(exp)) begin
            errors++;
            $display("FAIL %s: gnt_idx=%0d expected %0d", name, gnt_idx, exp);
        end
        m_ptr = exp;
        req   = '0;
        tick();
    endtask

    task automatic test_reset();
        rstb = 1'b0;
        req  = 4'b1111;
        ops[0] = 61'd10; ops[1] = 61'd20; ops[2] = 61'd30; ops[3] = 61'd40;
        #2;
        check_reset_outputs("reset_async");
        repeat (3) tick();
        check_reset_outputs("reset_held");
    endtask

    task automatic test_all_four();
        int cyc_at [5];
        int idx_at [5];
        logic [FB-1:0] c_at [5];
        int n = 0;
        int exp_idx [5] = '{0, 1, 2, 3, 0};
        logic [FB-1:0] exp_c [5];
        exp_c[0] = 61'd5; exp_c[1] = 61'd10; exp_c[2] = 61'd15; exp_c[3] = 61'd20; exp_c[4] = 61'd5;
        @(negedge clk);
        rstb  = 1'b1;
        m_ptr = N - 1;
        for (int cyc = 0; cyc < 100 && n < 5; cyc++) begin
            tick();
            if (done !== '0) begin
                cyc_at[n] = cyc;
                idx_at[n] = -1;
                for (int i = 0; i < N; i++) if (done == (4'b0001 << i)) idx_at[n] = i;
                c_at[n] = c;
                n++;
                if (n == 5) req = '0;
            end
        end
        checks++;
        if (n != 5) begin
            errors++;
            $display("FAIL all_four_count: saw %0d done strobes, expected 5", n);
        end
        for (int k = 0; k < n; k++) begin
            checks++;
            if (idx_at[k] != exp_idx[k] || c_at[k] !== exp_c[k]) begin
                errors++;
                $display("FAIL all_four_grant%0d: idx=%0d c=%0d expected idx=%0d c=%0d",
                         k, idx_at[k], c_at[k], exp_idx[k], exp_c[k]);
            end
            if (k > 0) begin
                checks++;
                if (cyc_at[k] - cyc_at[k-1] != FA + 3) begin
                    errors++;
                    $display("FAIL all_four_spacing%0d: %0d cycles, expected %0d",
                             k, cyc_at[k] - cyc_at[k-1], FA + 3);
                end
            end
        end
        m_ptr = 0;
        repeat (2) tick();
    endtask

    task automatic test_single(input int idx, input logic [FB-1:0] a,
                               input logic [FB-1:0] exp_c, input string name);
        int en_cnt   = 0;
        int done_cyc = -1;
        ops[idx] = a;
        req = 4'b0001 << idx;
        for (int cyc = 1; cyc <= FA + 5; cyc++) begin
            tick();
            if (dut.halve_en) en_cnt++;
            if (cyc == 1) begin
                checks++;
                if (gnt_vld !== 1'b1 || gnt_idx !== 2'(idx)) begin
                    errors++;
                    $display("FAIL %s_grant: gnt_vld=%b gnt_idx=%0d expected 1/%0d",
                             name, gnt_vld, gnt_idx, idx);
                end
            end
            if (done !== '0 && done_cyc < 0) begin
                done_cyc = cyc;
                checks++;
                if (done !== (4'b0001 << idx) || c !== exp_c) begin
                    errors++;
                    $display("FAIL %s_result: done=%b c=%h expected %b %h",
                             name, done, c, 4'b0001 << idx, exp_c);
                end
                req = '0;
            end
        end
        checks++;
        if (done_cyc != FA + 2 || en_cnt != 1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL %s_timing: done at +%0d en_cycles=%0d busy=%b expected +%0d 1 0",
                     name, done_cyc, en_cnt, busy, FA + 2);
        end
        m_ptr = idx;
    endtask

    task automatic test_fairness();
        int won;
        do_arb(4'b0010, "fair_setup1", won);
        do_arb(4'b0011, "fair_wrap", won);
        checks++;
        if (won != 0) begin
            errors++;
            $display("FAIL fair_wrap_winner: got %0d expected 0", won);
        end
        do_arb(4'b0010, "fair_setup2", won);
        do_arb(4'b1011, "fair_skip", won);
        checks++;
        if (won != 3) begin
            errors++;
            $display("FAIL fair_skip_winner: got %0d expected 3", won);
        end
    endtask

    task automatic test_reset_mid();
        int spurious = 0;
        int done_cyc = -1;
        ops[2] = 61'd1234;
        req = 4'b0100;
        tick();
        tick();
        rstb = 1'b0;
        req  = '0;
        #1;
        check_reset_outputs("reset_mid_async");
        for (int k = 0; k < 3; k++) begin
            tick();
            if (done !== '0) spurious++;
        end
        checks++;
        if (spurious != 0) begin
            errors++;
            $display("FAIL reset_mid_no_done: %0d done strobes during reset, expected 0", spurious);
        end
        ops[1] = 61'd77;
        req = 4'b0010;
        @(negedge clk);
        rstb  = 1'b1;
        m_ptr = N - 1;
        tick();
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_not_ready: busy=%b expected 0 while halver not ready", busy);
        end
        for (int cyc = 0; cyc < 30 && done_cyc < 0; cyc++) begin
            tick();
            if (done !== '0) done_cyc = cyc;
        end
        checks++;
        if (done !== 4'b0010 || c !== halve_ref(61'd77)) begin
            errors++;
            $display("FAIL reset_mid_first: done=%b c=%h expected 0010 %h",
                     done, c, halve_ref(61'd77));
        end
        req   = '0;
        m_ptr = 1;
        tick();
    endtask

    task automatic test_operand_hold();
        int en_cnt = 0;
        int bad_idx = 0;
        int done_cyc = -1;
        ops[3] = 61'd100;
        req = 4'b1000;
        for (int cyc = 1; cyc <= FA + 5; cyc++) begin
            tick();
            if (dut.halve_en) en_cnt++;
            if (busy && gnt_idx !== 2'd3) bad_idx++;
            if (cyc == 2) begin
                ops[3] = 61'd999;
                req = 4'b1011;
            end
            if (cyc == 3) req = 4'b1000;
            if (done !== '0 && done_cyc < 0) begin
                done_cyc = cyc;
                checks++;
                if (done !== 4'b1000 || c !== 61'd50) begin
                    errors++;
                    $display("FAIL hold_result: done=%b c=%0d expected 1000 50", done, c);
                end
                req = '0;
            end
        end
        checks++;
        if (en_cnt != 1 || bad_idx != 0 || done_cyc != FA + 2) begin
            errors++;
            $display("FAIL hold_single_op: en_cycles=%0d idx_changes=%0d done at +%0d expected 1 0 +%0d",
                     en_cnt, bad_idx, done_cyc, FA + 2);
        end
        m_ptr = 3;
    endtask

    task automatic test_random();
        int won;
        logic [N-1:0] mask;
        for (int it = 0; it < 12; it++) begin
            for (int i = 0; i < N; i++) begin
                case ($urandom_range(0, 5))
                    0:       ops[i] = P - 61'd1;
                    1:       ops[i] = '0;
                    default: ops[i] = FB'({$urandom(), $urandom()});
                endcase
                if (ops[i] == P) ops[i] = '0;
            end
            mask = 4'($urandom_range(1, 15));
            do_arb(mask, $sformatf("random%0d", it), won);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_all_four();
        test_single(2, 61'd6, 61'd3, "single_even");
        test_single(0, 61'd7, 61'h1000_0000_0000_0003, "single_odd");
        test_single(0, P - 61'd1, 61'h0FFF_FFFF_FFFF_FFFF, "single_pm1");
        test_fairness();
        test_reset_mid();
        test_operand_hold();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/field_halve_arb.md
# field_halve_arb

Round-robin arbiter that shares one `field_halve` instance (GF(p) a/2) among `n_req` requesters. It accepts one request at a time. The winner's operand is latched and issued to the halver with a one-cycle `en`. The result is returned with a one-cycle per-requester `done` strobe. It sits between the layer-computation units, which each need occasional halving, and a single halver, so the design does not replicate the adder datapath per unit.

## Interface
- `n_req`, default 4: number of requesters, legal range 2..16.
- `IW`, default `$clog2(n_req)`: grant index width (localparam).
- `clk`  in  1: clock.
- `rstb`  in  1: reset, asynchronous, active-low. Also drives `rstb` of the internal `field_halve`.
- `req`  in  `n_req`: request level per requester.
- `a_flat`  in  `n_req*F_NBITS`: operands. Requester i uses bits `[i*F_NBITS +: F_NBITS]`.
- `done`  out  `n_req`: one-hot, one-cycle result strobe.
- `c`  out  `F_NBITS`: registered result, valid while `done` != 0, held until the next completion.
- `gnt_vld`  out  1: high while a grant is outstanding (ISSUE, WAIT, DONE).
- `gnt_idx`  out  `IW`: index of the current or last grantee.
- `busy`  out  1: state != IDLE.

## Operation
- Requester protocol:
  - Raise `req[i]` and hold its operand stable until `done[i]`.
  - Drop `req[i]` in the cycle after `done[i]`.
  - If `req[i]` is still high at the next arbitration, it is a new request.
- State machine:
  - IDLE: if `|req` and halver `ready`=1, pick the winner, latch its operand into `a_q`, set `gnt_idx`, and go to ISSUE. Otherwise stay in IDLE.
  - ISSUE: drive halver `en`=1 with `a`=`a_q` for exactly this cycle, then go to WAIT.
  - WAIT: hold `en`=0. On halver `ready_pulse`, register halver `c` into `c` and go to DONE.
  - DONE: assert `done[gnt_idx]`=1 for this cycle only, then go to IDLE.
- Round-robin rule:
  - Pointer `ptr` holds the last granted index.
  - The search starts at `ptr+1` and wraps modulo `n_req`; the first set `req` bit wins.
  - `ptr` updates to the winner on the IDLE→ISSUE transition.
  - Reset value of `ptr` is `n_req-1`, so requester 0 has first priority.
- `req` changes while in ISSUE, WAIT or DONE have no effect. `a_flat` is sampled only on the IDLE→ISSUE edge.
- Arithmetic is performed entirely by `field_halve`: a even → a>>1; a odd → (a+p)>>1. The arbiter does not modify the operand or the result width (`F_NBITS`).

## Timing
- Reset values (async on `rstb`=0):
  - state=IDLE, `ptr`=`n_req-1`.
  - `done`=0, `c`=0, `gnt_vld`=0, `gnt_idx`=0, `busy`=0, `a_q`=0, halver `en`=0.
- Reset mid-operation: the in-flight result is discarded, no `done` is emitted, and all requests must be re-presented after reset.
- Latency, with the request seen in IDLE at cycle t:
  - `en` high at t+1.
  - Halver `ready_pulse` at t+1+`F_ADD_CYCLES`.
  - `c` valid and `done` high at t+2+`F_ADD_CYCLES`.
  - Back in IDLE at t+3+`F_ADD_CYCLES`.
- Throughput: one operation per `F_ADD_CYCLES`+3 cycles with continuous requests.
- Halver `ready`=0 in IDLE (for example right after reset): stay in IDLE, grant nothing.
- Simultaneous requests: exactly one grant per arbitration, chosen by round-robin. No requester waits more than `n_req`-1 other grants.
- Only one halver operation is ever in flight; `en` is never asserted outside ISSUE.
- A stray halver `ready_pulse` outside WAIT is ignored.

## Test plan
- Single request, with p = 2^61−1 and `F_NBITS`=61:
  - `req[2]`=1, a=6 → `done`=4'b0100 and `c`=3 at t+2+`F_ADD_CYCLES`.
  - `gnt_idx`=2 during the grant.
  - `en` is high for exactly one cycle.
- Odd operand: `req[0]`, a=7 → `c`=2^60+3. Then a=p−1 → `c`=(p−1)/2.
- All four `req` held high from reset with distinct operands 10, 20, 30, 40:
  - Grant order is 0,1,2,3,0.
  - Each `done` carries that requester's halved value: 5, 10, 15, 20.
  - Successive `done` strobes are `F_ADD_CYCLES`+3 cycles apart.
- Fairness after partial rotation:
  - Grant 1 completes, then `req`=4'b0011 → next grant is 0 (wraps past 2 and 3).
  - With `req`=4'b1011 instead → next grant is 3.
- `rstb` pulsed low during WAIT:
  - Outputs return to their reset values immediately.
  - No `done` is emitted.
  - After release, with `req[1]`=1, requester 1 is served first (ptr reset → search starts at 0, req[0]=0).
- `a_flat` for the granted requester changed during WAIT, and `req` toggled on other lines → `c` reflects the operand latched at grant, and no extra grant or `en` occurs before DONE.
